// File: rtl/fp_coproc_pkg.sv
// ---------------------------------------------------------------------------
// fp_coproc_pkg
// Shared definitions for the FP coprocessor issue slice: FSM state type,
// operation codes, rounding-mode codes and default widths.
// ---------------------------------------------------------------------------
package fp_coproc_pkg;

   typedef enum logic [1:0] {
      FP_IDLE = 2'd0,
      FP_WAIT = 2'd1,
      FP_RESP = 2'd2
   } fp_state_e;

   localparam logic       FP_OP_ADD = 1'b0;
   localparam logic       FP_OP_MUL = 1'b1;

   localparam logic [2:0] FP_RND_RNE = 3'd0;
   localparam logic [2:0] FP_RND_RTZ = 3'd1;
   localparam logic [2:0] FP_RND_RDN = 3'd2;
   localparam logic [2:0] FP_RND_RUP = 3'd3;
   localparam logic [2:0] FP_RND_RMM = 3'd4;

   localparam int FP_DATA_WIDTH_DEF = 16;
   localparam int FP_STATUS_BIT_DEF = 8;
   localparam int FP_LATENCY_DEF    = 2;
   localparam int FP_CNT_W          = 4;   // holds LATENCY up to 15

endpackage

// File: rtl/fp_issue_lat_cnt.sv
// ---------------------------------------------------------------------------
// fp_issue_lat_cnt
// Latency down-counter for the issue FSM. Load has priority over decrement;
// the count saturates at zero and o_done flags the zero state.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   i_load     : load i_load_val
//   i_load_val : value to load
//   i_dec      : decrement by one (ignored at zero)
//   o_done     : count is zero
// ---------------------------------------------------------------------------
module fp_issue_lat_cnt
   import fp_coproc_pkg::*;
#(
   parameter int CNT_W = FP_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/fp_coproc_issue.sv
// ---------------------------------------------------------------------------
// fp_coproc_issue
// Issues one FP request at a time to a fixed-latency coprocessor and returns
// the captured result with a valid/ready handshake.
//   clk, rst            : clock (rising) / async reset (active low)
//   req_*               : request handshake, operands, op, rounding, rd tag
//   cp_*_o              : registered operands/op/rnd to coprocessor
//   cp_data_i/status_i  : coprocessor result, sampled LATENCY+1 edges after
//                         acceptance
//   rsp_*               : response handshake, captured data/status/rd
//   busy_o              : not idle
// Optional: define FP_STICKY_STATUS_EN to add sticky_clr_i / sticky_status_o
// (accumulated OR of captured status).
// ---------------------------------------------------------------------------
module fp_coproc_issue
   import fp_coproc_pkg::*;
#(
   parameter int DATA_WIDTH = FP_DATA_WIDTH_DEF,
   parameter int STATUS_BIT = FP_STATUS_BIT_DEF,
   parameter int LATENCY    = FP_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_op_i,
   input  logic [2:0]            req_rnd_i,
   input  logic [DATA_WIDTH-1:0] req_a_i,
   input  logic [DATA_WIDTH-1:0] req_b_i,
   input  logic [3:0]            req_rd_i,
   output logic [DATA_WIDTH-1:0] cp_input1_o,
   output logic [DATA_WIDTH-1:0] cp_input2_o,
   output logic                  cp_op_o,
   output logic [2:0]            cp_rnd_o,
   input  logic [DATA_WIDTH-1:0] cp_data_i,
   input  logic [STATUS_BIT-1:0] cp_status_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic [STATUS_BIT-1:0] rsp_status_o,
   output logic [3:0]            rsp_rd_o,
   output logic                  busy_o
`ifdef FP_STICKY_STATUS_EN
   ,
   input  logic                  sticky_clr_i,
   output logic [STATUS_BIT-1:0] sticky_status_o
`endif
);

   localparam logic [FP_CNT_W-1:0] LAT_LOAD = FP_CNT_W'(LATENCY);

   fp_state_e             r_state;
   logic [DATA_WIDTH-1:0] r_cp_a;
   logic [DATA_WIDTH-1:0] r_cp_b;
   logic                  r_cp_op;
   logic [2:0]            r_cp_rnd;
   logic [3:0]            r_rd;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [STATUS_BIT-1:0] r_rsp_status;
   logic [3:0]            r_rsp_rd;

   logic w_accept;
   logic w_done;
   logic w_in_wait;
   logic w_capture;

   assign req_ready_o = (r_state == FP_IDLE) || ((r_state == FP_RESP) && rsp_ready_i);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_in_wait   = (r_state == FP_WAIT);
   // Counter reaches zero on the LATENCY-th WAIT edge; the next edge captures.
   assign w_capture   = w_in_wait && w_done;

   fp_issue_lat_cnt #(
      .CNT_W (FP_CNT_W)
   ) u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_load_val (LAT_LOAD),
      .i_dec      (w_in_wait && !w_done),
      .o_done     (w_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FP_IDLE;
      end else begin
         unique case (r_state)
            FP_IDLE: if (w_accept)  r_state <= FP_WAIT;
            FP_WAIT: if (w_done)    r_state <= FP_RESP;
            FP_RESP: begin
               // Back-to-back acceptance skips IDLE entirely.
               if (w_accept)         r_state <= FP_WAIT;
               else if (rsp_ready_i) r_state <= FP_IDLE;
            end
            default:                 r_state <= FP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cp_a       <= '0;
         r_cp_b       <= '0;
         r_cp_op      <= FP_OP_ADD;
         r_cp_rnd     <= FP_RND_RNE;
         r_rd         <= '0;
         r_rsp_data   <= '0;
         r_rsp_status <= '0;
         r_rsp_rd     <= '0;
      end else begin
         if (w_accept) begin
            r_cp_a   <= req_a_i;
            r_cp_b   <= req_b_i;
            r_cp_op  <= req_op_i;
            r_cp_rnd <= req_rnd_i;
            r_rd     <= req_rd_i;
         end
         if (w_capture) begin
            r_rsp_data   <= cp_data_i;
            r_rsp_status <= cp_status_i;
            r_rsp_rd     <= r_rd;
         end
      end
   end

`ifdef FP_STICKY_STATUS_EN
   logic [STATUS_BIT-1:0] r_sticky;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sticky <= '0;
      end else if (w_capture) begin
         // A same-edge clear drops history but keeps the new status.
         r_sticky <= (sticky_clr_i ? '0 : r_sticky) | cp_status_i;
      end else if (sticky_clr_i) begin
         r_sticky <= '0;
      end
   end

   assign sticky_status_o = r_sticky;
`endif

   assign cp_input1_o  = r_cp_a;
   assign cp_input2_o  = r_cp_b;
   assign cp_op_o      = r_cp_op;
   assign cp_rnd_o     = r_cp_rnd;
   assign rsp_valid_o  = (r_state == FP_RESP);
   assign rsp_data_o   = r_rsp_data;
   assign rsp_status_o = r_rsp_status;
   assign rsp_rd_o     = r_rsp_rd;
   assign busy_o       = (r_state != FP_IDLE);

endmodule

// File: tb/tb_fp_coproc_issue.sv
module tb_fp_coproc_issue;
   import fp_coproc_pkg::*;

   localparam int DW  = 16;
   localparam int SW  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_op_i;
   logic [2:0]    req_rnd_i;
   logic [DW-1:0] req_a_i;
   logic [DW-1:0] req_b_i;
   logic [3:0]    req_rd_i;
   logic [DW-1:0] cp_input1_o;
   logic [DW-1:0] cp_input2_o;
   logic          cp_op_o;
   logic [2:0]    cp_rnd_o;
   logic [DW-1:0] cp_data_i;
   logic [SW-1:0] cp_status_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_data_o;
   logic [SW-1:0] rsp_status_o;
   logic [3:0]    rsp_rd_o;
   logic          busy_o;
   logic          sticky_clr_i;
`ifdef FP_STICKY_STATUS_EN
   logic [SW-1:0] sticky_status_o;
`endif

   always #5 clk = ~clk;

   fp_coproc_issue #(
      .DATA_WIDTH (DW),
      .STATUS_BIT (SW),
      .LATENCY    (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_rnd_i    (req_rnd_i),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_rd_i     (req_rd_i),
      .cp_input1_o  (cp_input1_o),
      .cp_input2_o  (cp_input2_o),
      .cp_op_o      (cp_op_o),
      .cp_rnd_o     (cp_rnd_o),
      .cp_data_i    (cp_data_i),
      .cp_status_i  (cp_status_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_status_o (rsp_status_o),
      .rsp_rd_o     (rsp_rd_o),
      .busy_o       (busy_o)
`ifdef FP_STICKY_STATUS_EN
      ,
      .sticky_clr_i    (sticky_clr_i),
      .sticky_status_o (sticky_status_o)
`endif
   );

   int n_err = 0;
   int n_chk = 0;

   // Reference model: one outstanding op, its age in cycles since acceptance,
   // and the values every output should currently show.
   bit            m_pend, m_resp;
   int            m_age;
   logic [DW-1:0] m_cp_a, m_cp_b, m_res, m_rsp_data;
   logic          m_cp_op;
   logic [2:0]    m_cp_rnd;
   logic [3:0]    m_rd, m_rsp_rd;
   logic [SW-1:0] m_st, m_rsp_st, m_sticky, next_status;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stand-in coprocessor arithmetic: known fp16 cases, otherwise any
   // deterministic function of the operands.
   function automatic logic [DW-1:0] coproc_fn(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (op == FP_OP_ADD && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
      if (op == FP_OP_MUL && a == 16'h4000 && b == 16'h4200) return 16'h4600;
      if (op == FP_OP_MUL) return DW'(a * b);
      return DW'(a + b);
   endfunction

   task automatic model_reset();
      m_pend = 0; m_resp = 0; m_age = 0;
      m_cp_a = '0; m_cp_b = '0; m_cp_op = 1'b0; m_cp_rnd = '0; m_rd = '0;
      m_res = '0; m_st = '0;
      m_rsp_data = '0; m_rsp_st = '0; m_rsp_rd = '0; m_sticky = '0;
   endtask

   task automatic check_all();
      logic exp_ready;
      exp_ready = !m_pend || (m_resp && rsp_ready_i);
      chk("req_ready", req_ready_o, exp_ready);
      chk("rsp_valid", rsp_valid_o, m_resp);
      chk("busy", busy_o, m_pend);
      chk("cp_input1", cp_input1_o, m_cp_a);
      chk("cp_input2", cp_input2_o, m_cp_b);
      chk("cp_op", cp_op_o, m_cp_op);
      chk("cp_rnd", cp_rnd_o, m_cp_rnd);
      chk("rsp_data", rsp_data_o, m_rsp_data);
      chk("rsp_status", rsp_status_o, m_rsp_st);
      chk("rsp_rd", rsp_rd_o, m_rsp_rd);
`ifdef FP_STICKY_STATUS_EN
      chk("sticky", sticky_status_o, m_sticky);
`endif
   endtask

   // Called at a negedge with inputs set: check, drive coprocessor, clock, update model.
   task automatic step();
      logic exp_ready, acc, cap;
      #1;
      check_all();
      exp_ready = !m_pend || (m_resp && rsp_ready_i);
      cap = m_pend && !m_resp && (m_age == LAT);
      // Only the capturing cycle carries the real result; other cycles differ.
      if (cap) begin
         cp_data_i   = m_res;
         cp_status_i = m_st;
      end else begin
         cp_data_i   = m_res ^ DW'($urandom_range(1, 65535));
         cp_status_i = m_st ^ SW'($urandom_range(1, 255));
      end
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         acc = req_valid_i && exp_ready;
         if (m_resp && rsp_ready_i) begin
            m_resp = 0;
            m_pend = 0;
         end else if (cap) begin
            m_resp = 1;
            m_rsp_data = m_res;
            m_rsp_st   = m_st;
            m_rsp_rd   = m_rd;
         end else if (m_pend && !m_resp) begin
            m_age++;
         end
         if (cap)               m_sticky = (sticky_clr_i ? '0 : m_sticky) | m_st;
         else if (sticky_clr_i) m_sticky = '0;
         if (acc) begin
            m_pend = 1; m_resp = 0; m_age = 0;
            m_cp_a = req_a_i; m_cp_b = req_b_i;
            m_cp_op = req_op_i; m_cp_rnd = req_rnd_i; m_rd = req_rd_i;
            m_res = coproc_fn(req_op_i, req_a_i, req_b_i);
            m_st  = next_status;
            next_status = SW'($urandom);
         end
      end
      @(negedge clk);
   endtask

   task automatic present(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op,
                          input logic [2:0] rnd, input logic [3:0] rd);
      req_valid_i = 1'b1;
      req_a_i = a; req_b_i = b; req_op_i = op; req_rnd_i = rnd; req_rd_i = rd;
   endtask

   initial begin
      rst = 1'b0;
      req_valid_i = 0; req_op_i = 0; req_rnd_i = '0; req_a_i = '0; req_b_i = '0; req_rd_i = '0;
      rsp_ready_i = 0; sticky_clr_i = 0;
      cp_data_i = '0; cp_status_i = '0;
      next_status = '0;
      model_reset();

      // Reset state
      @(negedge clk);
      step();
      step();
      rst = 1'b1;

      // Add 1.0 + 2.0 -> 3.0 (0x4200), rd 5, valid exactly 3 cycles later
      next_status = 8'h00;
      present(16'h3C00, 16'h4000, FP_OP_ADD, FP_RND_RNE, 4'd5);
      step();
      req_valid_i = 0;
      step(); step(); step();
      #1;
      chk("add_valid_after_3", rsp_valid_o, 1'b1);
      chk("add_data", rsp_data_o, 16'h4200);
      chk("add_rd", rsp_rd_o, 4'd5);

      // Backpressure: 4 cycles held, then release returns to IDLE
      repeat (4) step();
      rsp_ready_i = 1;
      step();
      rsp_ready_i = 0;
      step();
      chk("idle_after_release", busy_o, 1'b0);

      // Back-to-back: second request accepted on the response edge
      next_status = 8'h01;
      present(16'h3C00, 16'h4000, FP_OP_ADD, FP_RND_RNE, 4'd5);
      step();
      req_valid_i = 0;
      step(); step(); step();
      next_status = 8'h04;
      rsp_ready_i = 1;
      present(16'h4000, 16'h4200, FP_OP_MUL, FP_RND_RTZ, 4'd7);
      step();
      req_valid_i = 0; rsp_ready_i = 0;
      #1;
      chk("b2b_cp_a", cp_input1_o, 16'h4000);
      chk("b2b_cp_b", cp_input2_o, 16'h4200);
      chk("b2b_cp_op", cp_op_o, 1'b1);
      chk("b2b_busy", busy_o, 1'b1);
      // Request during WAIT is ignored
      present(16'h1111, 16'h2222, FP_OP_ADD, FP_RND_RUP, 4'd9);
      step();
      chk("wait_ready_low", req_ready_o, 1'b0);
      req_valid_i = 0;
      step(); step();
      #1;
      chk("mul_data", rsp_data_o, 16'h4600);
      chk("mul_rd", rsp_rd_o, 4'd7);
`ifdef FP_STICKY_STATUS_EN
      chk("sticky_or", sticky_status_o, 8'h05);
      rsp_ready_i = 1; sticky_clr_i = 1;
      step();
      rsp_ready_i = 0; sticky_clr_i = 0;
      #1;
      chk("sticky_clr", sticky_status_o, 8'h00);
`else
      rsp_ready_i = 1;
      step();
      rsp_ready_i = 0;
`endif

      // Reset one cycle into WAIT discards the operation
      present(16'h0123, 16'h0456, FP_OP_MUL, FP_RND_RDN, 4'd3);
      step();
      req_valid_i = 0;
      step();
      rst = 1'b0;
      #1;
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_cp_a", cp_input1_o, '0);
      chk("arst_cp_op", cp_op_o, 1'b0);
      chk("arst_rsp_valid", rsp_valid_o, 1'b0);
      model_reset();
      @(negedge clk);
      step();
      rst = 1'b1;
      repeat (4) step();
      next_status = 8'h20;
      present(16'h3C00, 16'h4000, FP_OP_ADD, FP_RND_RMM, 4'd12);
      step();
      req_valid_i = 0;
      step(); step(); step();
      #1;
      chk("post_reset_data", rsp_data_o, 16'h4200);
      chk("post_reset_rd", rsp_rd_o, 4'd12);

      // Randomized traffic against the model
      for (int i = 0; i < 120; i++) begin
         req_valid_i  = 1'($urandom_range(0, 1));
         req_a_i      = DW'($urandom);
         req_b_i      = DW'($urandom);
         req_op_i     = 1'($urandom_range(0, 1));
         req_rnd_i    = 3'($urandom_range(0, 4));
         req_rd_i     = 4'($urandom);
         rsp_ready_i  = ($urandom_range(0, 3) != 0);
         sticky_clr_i = ($urandom_range(0, 7) == 0);
         step();
      end
      req_valid_i = 0; rsp_ready_i = 1; sticky_clr_i = 0;
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
